// File: rtl/passive_stim_gen.sv
// Pattern stimulus generator: emits num_vec vectors (count/walk/gray/LFSR), each held
// hold+1 cycles, followed by a one-cycle flush and a one-cycle done pulse.
module passive_stim_gen #(
  parameter int              WIDTH     = 3,
  parameter int              CNT_W     = 8,
  parameter int              HOLD_W    = 4,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(3'b110)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [HOLD_W-1:0] hold,
  output logic [WIDTH-1:0]  stim,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  state_t            stateR;
  logic [1:0]        modeR;
  logic [CNT_W-1:0]  numR;
  logic [HOLD_W-1:0] holdR;
  logic [CNT_W-1:0]  vecCnt;
  logic [HOLD_W-1:0] holdCnt;
  logic [WIDTH-1:0]  binR;

  assign dbgState = stateR;

  function automatic logic [WIDTH-1:0] seedVec(input logic [1:0] m);
    seedVec = (m == 2'd1 || m == 2'd3) ? WIDTH'(1) : '0;
  endfunction

  // Gray mode derives the output from the binary shadow counter, not from stim itself.
  function automatic logic [WIDTH-1:0] nextVec(input logic [1:0] m,
                                               input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] nb;
    nb = b + 1'b1;
    case (m)
      2'd0:    nextVec = s + 1'b1;
      2'd1:    nextVec = {s[WIDTH-2:0], s[WIDTH-1]};
      2'd2:    nextVec = nb ^ (nb >> 1);
      default: nextVec = {s[WIDTH-2:0], ^(s & LFSR_TAPS)};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stateR     <= IDLE;
      modeR      <= '0;
      numR       <= '0;
      holdR      <= '0;
      vecCnt     <= '0;
      holdCnt    <= '0;
      binR       <= '0;
      stim       <= '0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            modeR   <= mode;
            numR    <= num_vec;
            holdR   <= hold;
            vecCnt  <= '0;
            holdCnt <= '0;
            binR    <= '0;
            busy    <= 1'b1;
            if (num_vec != '0) begin
              stateR     <= RUN;
              stim       <= seedVec(mode);
              stim_valid <= 1'b1;
            end else begin
              stateR     <= FLUSH;
              stim       <= '0;
              stim_valid <= 1'b0;
            end
          end
        end
        RUN: begin
          if (holdCnt == holdR) begin
            holdCnt <= '0;
            if (vecCnt == numR - 1'b1) begin
              stateR     <= FLUSH;
              stim       <= '0;
              stim_valid <= 1'b0;
            end else begin
              vecCnt <= vecCnt + 1'b1;
              binR   <= binR + 1'b1;
              stim   <= nextVec(modeR, stim, binR);
            end
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        FLUSH: begin
          stateR     <= DONE;
          stim       <= '0;
          stim_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        default: begin
          stateR <= IDLE;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_passive_stim_gen.sv
// Bench for passive_stim_gen: fixed vector table, hand-written corner sequences and
// random jobs scored against an arithmetic model of the pattern rules.
module tb_passive_stim_gen;
  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [7:0]   num_vec;
  logic [3:0]   hold;
  logic [W-1:0] stim;
  logic         stim_valid;
  logic         busy;
  logic         done;
  logic [1:0]   dbgState;

  int total = 0;
  int bad   = 0;
  logic [W+2:0] exp_q[$];

  passive_stim_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vec(num_vec),
    .hold(hold), .stim(stim), .stim_valid(stim_valid), .busy(busy), .done(done),
    .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] m;
    int         n;
    int         h;
    logic [29:0] seq;
    int         doneCycle;
  } tv_t;

  tv_t tbl[6];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] obs();
    return {stim, stim_valid, busy, done};
  endfunction

  // Reference: vector k of a job, straight from the pattern rules.
  function automatic logic [W-1:0] model_vec(input logic [1:0] m, input int k);
    int g;
    logic [W-1:0] s;
    case (m)
      2'd0: return W'(k % (1 << W));
      2'd1: return W'(1 << (k % W));
      2'd2: begin
        g = k % (1 << W);
        return W'(g ^ (g >> 1));
      end
      default: begin
        s = W'(1);
        for (int i = 0; i < k; i++) s = {s[W-2:0], ^(s & 3'b110)};
        return s;
      end
    endcase
  endfunction

  task automatic scramble();
    mode    = 2'($urandom_range(0, 3));
    num_vec = 8'($urandom_range(0, 255));
    hold    = 4'($urandom_range(0, 15));
  endtask

  // driver + scoreboard for one job; start may be re-pulsed at cycle pulseAt
  task automatic run_job(input string name, input logic [1:0] m, input int n, input int h,
                         input int pulseAt, input int extraIdle);
    int c;
    logic [W+2:0] e;
    for (int k = 0; k < n; k++)
      for (int r = 0; r <= h; r++) exp_q.push_back({model_vec(m, k), 3'b110});
    exp_q.push_back({{W{1'b0}}, 3'b010});
    exp_q.push_back({{W{1'b0}}, 3'b001});
    for (int i = 0; i < extraIdle; i++) exp_q.push_back('0);
    @(negedge clk);
    mode = m; num_vec = 8'(n); hold = 4'(h); start = 1'b1;
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      c++;
      e = exp_q.pop_front();
      cmp(name, 32'(obs()), 32'(e));
      start = (c == pulseAt);
      scramble();
    end
    start = 1'b0;
  endtask

  initial begin
    int L;
    logic [W+2:0] e;
    tbl[0] = '{"t1_count5", 2'd0, 5, 0,
               {3'd0,3'd0,3'd0,3'd0,3'd0,3'd4,3'd3,3'd2,3'd1,3'd0}, 7};
    tbl[1] = '{"t2_count_wrap", 2'd0, 10, 0,
               {3'd1,3'd0,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 12};
    tbl[2] = '{"t3_walk_hold2", 2'd1, 4, 2,
               {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd4,3'd2,3'd1}, 14};
    tbl[3] = '{"t4_lfsr", 2'd3, 7, 0,
               {3'd0,3'd0,3'd0,3'd4,3'd6,3'd7,3'd3,3'd5,3'd2,3'd1}, 9};
    tbl[4] = '{"t4_gray", 2'd2, 4, 0,
               {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd2,3'd3,3'd1,3'd0}, 6};
    tbl[5] = '{"t5_zero", 2'd0, 0, 0, 30'd0, 2};

    reset = 1'b1; start = 1'b0; mode = '0; num_vec = '0; hold = '0;
    repeat (3) @(negedge clk);
    cmp("reset_outputs", 32'(obs()), 32'd0);
    cmp("reset_state", 32'(dbgState), 32'd0);
    reset = 1'b0;

    // table-driven jobs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mode = tbl[i].m; num_vec = 8'(tbl[i].n); hold = 4'(tbl[i].h); start = 1'b1;
      L = tbl[i].n * (tbl[i].h + 1);
      for (int c = 1; c <= tbl[i].doneCycle + 1; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (c <= L)
          e = {tbl[i].seq[((c - 1) / (tbl[i].h + 1)) * 3 +: 3], 3'b110};
        else if (c == tbl[i].doneCycle)
          e = {{W{1'b0}}, 3'b001};
        else if (c == tbl[i].doneCycle - 1)
          e = {{W{1'b0}}, 3'b010};
        else
          e = '0;
        cmp(tbl[i].name, 32'(obs()), 32'(e));
        if (tbl[i].m == 2'd3 && stim_valid) cmp("lfsr_nonzero", 32'(stim != '0), 32'd1);
        scramble();
      end
    end

    // start re-pulsed mid-run and during the DONE cycle: both ignored
    run_job("start_mid_run", 2'd0, 5, 0, 3, 2);
    run_job("start_in_done", 2'd2, 3, 1, 8, 2);

    // reset in the middle of a run
    @(negedge clk);
    mode = 2'd0; num_vec = 8'd5; hold = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp("rst_run_c1", 32'(obs()), 32'({3'd0, 3'b110}));
    @(negedge clk);
    cmp("rst_run_c2", 32'(obs()), 32'({3'd1, 3'b110}));
    reset = 1'b1;
    @(negedge clk);
    cmp("rst_run_c3", 32'(obs()), 32'd0);
    cmp("rst_run_state", 32'(dbgState), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("rst_no_done", 32'(obs()), 32'd0);
    end
    run_job("after_reset", 2'd0, 3, 0, -1, 1);

    // random jobs
    for (int j = 0; j < 25; j++)
      run_job("random_job", 2'($urandom_range(0, 3)), $urandom_range(0, 12),
              $urandom_range(0, 3), -1, $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
